// File: rtl/bus_datapath_seq_if.sv
// Handshake, operand, load and observation signals of the bus datapath sequencer.
interface bus_datapath_seq_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
);
    localparam int AW = $clog2(NUM_REGS);

    logic              start;
    logic [2:0]        op;
    logic [AW-1:0]     ra;
    logic [AW-1:0]     rb;
    logic [AW-1:0]     rc;
    logic              ld_en;
    logic [AW-1:0]     ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] bus_out;
    logic              busy;
    logic              done;
    logic              div0;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, op, ra, rb, rc, ld_en, ld_addr, ld_data, rd_addr,
        input  rd_data, bus_out, busy, done, div0, hi, lo
    );

    modport slave (
        input  start, op, ra, rb, rc, ld_en, ld_addr, ld_data, rd_addr,
        output rd_data, bus_out, busy, done, div0, hi, lo
    );
endinterface

// File: rtl/bus_datapath_seq.sv
// Single-bus register-file datapath: one operation moves operands over a shared
// bus into Y and the ALU, then writes the result back to R[ra] or to LO/HI.
//
// state | meaning
// IDLE  | waiting for start; bus shows R[rd_addr]; external loads accepted
// TY    | bus = R[rb], captured into Y
// TEX   | bus = R[rc]; ALU result captured into {Z_HI, Z_LO}
// TWB   | bus = Z_LO; written to R[ra] (ops 0-5) or LO (MUL/DIV)
// THI   | bus = Z_HI; written to HI
module bus_datapath_seq #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ZERO_R0  = 1
) (
    input logic          clk,
    input logic          clr,
    bus_datapath_seq_if.slave bif
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int SW = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_TY, S_TEX, S_TWB, S_THI} state_t;

    state_t r_state;
    state_t w_next;

    logic [2:0]        r_op;
    logic [AW-1:0]     r_ra;
    logic [AW-1:0]     r_rb;
    logic [AW-1:0]     r_rc;
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_y;
    logic [DATA_W-1:0] r_z_hi;
    logic [DATA_W-1:0] r_z_lo;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic              r_done;
    logic              r_div0;

    logic                     w_start_ok;
    logic                     w_mul_div;
    logic                     w_ld_ok;
    logic                     w_wb_ok;
    logic [DATA_W-1:0]        w_bus;
    logic [DATA_W-1:0]        w_alu_hi;
    logic [DATA_W-1:0]        w_alu_lo;
    logic                     w_div0;
    logic                     w_div_zero;
    logic                     w_div_ovf;
    logic [DATA_W-1:0]        w_den;
    logic signed [DATA_W-1:0] w_ys;
    logic signed [DATA_W-1:0] w_ds;
    logic signed [DATA_W-1:0] w_quo;
    logic signed [DATA_W-1:0] w_rem;
    logic [2*DATA_W-1:0]      w_prod;

    assign w_start_ok = (r_state == S_IDLE) && bif.start;
    assign w_mul_div  = r_op[2] & r_op[1];
    assign w_ld_ok    = (r_state == S_IDLE) && bif.ld_en &&
                        !((ZERO_R0 != 0) && (bif.ld_addr == '0));
    assign w_wb_ok    = (r_state == S_TWB) && !w_mul_div &&
                        !((ZERO_R0 != 0) && (r_ra == '0));

    // Low 2*DATA_W bits of the product of sign-extended operands equal the signed product.
    assign w_prod = {{DATA_W{r_y[DATA_W-1]}}, r_y} * {{DATA_W{w_bus[DATA_W-1]}}, w_bus};

    // Divisor is forced to 1 in the two special cases so the divider never sees them.
    assign w_div_zero = (w_bus == '0);
    assign w_div_ovf  = (r_y == MIN_NEG) && (w_bus == '1);
    assign w_den      = (w_div_zero || w_div_ovf) ? {{(DATA_W-1){1'b0}}, 1'b1} : w_bus;
    assign w_ys       = r_y;
    assign w_ds       = w_den;
    assign w_quo      = w_ys / w_ds;
    assign w_rem      = w_ys % w_ds;

    assign bif.rd_data = r_regs[bif.rd_addr];
    assign bif.bus_out = w_bus;
    assign bif.busy    = (r_state != S_IDLE);
    assign bif.done    = r_done;
    assign bif.div0    = r_div0;
    assign bif.hi      = r_hi;
    assign bif.lo      = r_lo;

    // Bus source select per state.
    always_comb begin
        w_bus = r_regs[bif.rd_addr];
        case (r_state)
            S_TY:    w_bus = r_regs[r_rb];
            S_TEX:   w_bus = r_regs[r_rc];
            S_TWB:   w_bus = r_z_lo;
            S_THI:   w_bus = r_z_hi;
            default: w_bus = r_regs[bif.rd_addr];
        endcase
    end

    // ALU: Y against the bus operand.
    always_comb begin
        w_alu_hi = '0;
        w_alu_lo = '0;
        w_div0   = 1'b0;
        case (r_op)
            3'd0: w_alu_lo = r_y + w_bus;
            3'd1: w_alu_lo = r_y - w_bus;
            3'd2: w_alu_lo = r_y & w_bus;
            3'd3: w_alu_lo = r_y | w_bus;
            3'd4: w_alu_lo = r_y << w_bus[SW-1:0];
            3'd5: w_alu_lo = r_y >> w_bus[SW-1:0];
            3'd6: {w_alu_hi, w_alu_lo} = w_prod;
            default: begin
                if (w_div_zero) begin
                    w_alu_lo = '1;
                    w_alu_hi = r_y;
                    w_div0   = 1'b1;
                end else if (w_div_ovf) begin
                    w_alu_lo = MIN_NEG;
                    w_alu_hi = '0;
                end else begin
                    w_alu_lo = w_quo;
                    w_alu_hi = w_rem;
                end
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bif.start) w_next = S_TY;
            S_TY:    w_next = S_TEX;
            S_TEX:   w_next = S_TWB;
            S_TWB:   w_next = w_mul_div ? S_THI : S_IDLE;
            S_THI:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand latch, Y/Z/HI/LO capture, done and div0 flags.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_op   <= '0;
            r_ra   <= '0;
            r_rb   <= '0;
            r_rc   <= '0;
            r_y    <= '0;
            r_z_hi <= '0;
            r_z_lo <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
            r_div0 <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start_ok) begin
                r_op   <= bif.op;
                r_ra   <= bif.ra;
                r_rb   <= bif.rb;
                r_rc   <= bif.rc;
                r_div0 <= 1'b0;
            end
            case (r_state)
                S_TY:  r_y <= w_bus;
                S_TEX: begin
                    r_z_hi <= w_alu_hi;
                    r_z_lo <= w_alu_lo;
                    if (w_div0) r_div0 <= 1'b1;
                end
                S_TWB: begin
                    if (w_mul_div) r_lo <= w_bus;
                    else           r_done <= 1'b1;
                end
                S_THI: begin
                    r_hi   <= w_bus;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Register file: external load in IDLE, result writeback in TWB.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_ld_ok) begin
            r_regs[bif.ld_addr] <= bif.ld_data;
        end else if (w_wb_ok) begin
            r_regs[r_ra] <= w_bus;
        end
    end
endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed bench for bus_datapath_seq: 32-bit/16-register and 16-bit/8-register instances.
module tb_bus_datapath_seq;
    logic clk = 1'b0;
    logic clr;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    bus_datapath_seq_if #(.DATA_W(32), .NUM_REGS(16)) b32 ();
    bus_datapath_seq_if #(.DATA_W(16), .NUM_REGS(8))  b16 ();

    bus_datapath_seq #(.DATA_W(32), .NUM_REGS(16), .ZERO_R0(1)) u_dut32 (
        .clk (clk),
        .clr (clr),
        .bif (b32)
    );

    bus_datapath_seq #(.DATA_W(16), .NUM_REGS(8), .ZERO_R0(1)) u_dut16 (
        .clk (clk),
        .clr (clr),
        .bif (b16)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic ld32(input logic [3:0] a, input logic [31:0] d);
        b32.ld_en = 1'b1; b32.ld_addr = a; b32.ld_data = d;
        @(negedge clk);
        b32.ld_en = 1'b0;
    endtask

    task automatic ld16(input logic [2:0] a, input logic [15:0] d);
        b16.ld_en = 1'b1; b16.ld_addr = a; b16.ld_data = d;
        @(negedge clk);
        b16.ld_en = 1'b0;
    endtask

    task automatic rd32(input logic [3:0] a, output logic [31:0] d);
        b32.rd_addr = a;
        #1;
        d = b32.rd_data;
    endtask

    task automatic rd16(input logic [2:0] a, output logic [15:0] d);
        b16.rd_addr = a;
        #1;
        d = b16.rd_data;
    endtask

    // Issues one operation and waits (bounded) for done; returns edges after the start edge,
    // number of busy cycles, and done as seen one cycle after it rose.
    task automatic op32(input logic [2:0] op, input logic [3:0] ra, rb, rc,
                        output int edges, output int busy_n, output logic done_next);
        b32.start = 1'b1; b32.op = op; b32.ra = ra; b32.rb = rb; b32.rc = rc;
        @(negedge clk);
        b32.start = 1'b0; b32.ld_en = 1'b0;
        edges  = 0;
        busy_n = b32.busy ? 1 : 0;
        while (!b32.done && edges < 20) begin
            @(negedge clk);
            edges++;
            if (b32.busy) busy_n++;
        end
        @(negedge clk);
        done_next = b32.done;
    endtask

    task automatic op16(input logic [2:0] op, input logic [2:0] ra, rb, rc,
                        output int edges, output int busy_n, output logic done_next);
        b16.start = 1'b1; b16.op = op; b16.ra = ra; b16.rb = rb; b16.rc = rc;
        @(negedge clk);
        b16.start = 1'b0; b16.ld_en = 1'b0;
        edges  = 0;
        busy_n = b16.busy ? 1 : 0;
        while (!b16.done && edges < 20) begin
            @(negedge clk);
            edges++;
            if (b16.busy) busy_n++;
        end
        @(negedge clk);
        done_next = b16.done;
    endtask

    initial begin
        logic [31:0] d32;
        logic [15:0] d16;
        int          e, bn, pulses;
        logic        dn;

        clr = 1'b1;
        b32.start = 0; b32.op = 0; b32.ra = 0; b32.rb = 0; b32.rc = 0;
        b32.ld_en = 0; b32.ld_addr = 0; b32.ld_data = 0; b32.rd_addr = 0;
        b16.start = 0; b16.op = 0; b16.ra = 0; b16.rb = 0; b16.rc = 0;
        b16.ld_en = 0; b16.ld_addr = 0; b16.ld_data = 0; b16.rd_addr = 0;
        repeat (2) @(negedge clk);
        clr = 1'b0;

        // Reset state
        check("rst_busy", b32.busy, 0);
        check("rst_done", b32.done, 0);
        check("rst_div0", b32.div0, 0);
        check("rst_hi", b32.hi, 0);
        check("rst_lo", b32.lo, 0);
        rd32(4'd5, d32); check("rst_r5", d32, 0);
        check("rst16_busy", b16.busy, 0);

        // ADD
        ld32(4'd2, 32'd5); ld32(4'd4, 32'd7);
        op32(3'd0, 4'd5, 4'd2, 4'd4, e, bn, dn);
        rd32(4'd5, d32); check("add_r5", d32, 32'd12);
        check("add_edges", e, 3);
        check("add_busy_cycles", bn, 3);
        check("add_done_one_cycle", dn, 0);

        // MUL
        ld32(4'd2, 32'hFFFF_FFFA); ld32(4'd4, 32'd4);
        op32(3'd6, 4'd5, 4'd2, 4'd4, e, bn, dn);
        check("mul_lo", b32.lo, 32'hFFFF_FFE8);
        check("mul_hi", b32.hi, 32'hFFFF_FFFF);
        check("mul_edges", e, 4);
        check("mul_busy_cycles", bn, 4);
        rd32(4'd5, d32); check("mul_r5_kept", d32, 32'd12);
        rd32(4'd2, d32); check("mul_r2_kept", d32, 32'hFFFF_FFFA);

        // DIV, then divide by zero
        ld32(4'd2, 32'hFFFF_FFF9); ld32(4'd4, 32'd2);
        op32(3'd7, 4'd5, 4'd2, 4'd4, e, bn, dn);
        check("div_lo", b32.lo, 32'hFFFF_FFFD);
        check("div_hi", b32.hi, 32'hFFFF_FFFF);
        check("div_div0", b32.div0, 0);
        ld32(4'd4, 32'd0);
        op32(3'd7, 4'd5, 4'd2, 4'd4, e, bn, dn);
        check("div0_lo", b32.lo, 32'hFFFF_FFFF);
        check("div0_hi", b32.hi, 32'hFFFF_FFF9);
        check("div0_flag", b32.div0, 1);
        check("div0_edges", e, 4);

        // Most negative / -1; start also clears div0
        ld32(4'd2, 32'h8000_0000); ld32(4'd4, 32'hFFFF_FFFF);
        op32(3'd7, 4'd5, 4'd2, 4'd4, e, bn, dn);
        check("ovf_lo", b32.lo, 32'h8000_0000);
        check("ovf_hi", b32.hi, 32'h0);
        check("ovf_div0_cleared", b32.div0, 0);

        // R0 hardwired zero, shifts
        ld32(4'd0, 32'd9);
        rd32(4'd0, d32); check("r0_load_ignored", d32, 0);
        ld32(4'd2, 32'd1); ld32(4'd4, 32'd33);
        op32(3'd4, 4'd5, 4'd2, 4'd4, e, bn, dn);
        rd32(4'd5, d32); check("shl_mod_width", d32, 32'd2);
        ld32(4'd2, 32'h8000_0000); ld32(4'd4, 32'd4);
        op32(3'd5, 4'd8, 4'd2, 4'd4, e, bn, dn);
        rd32(4'd8, d32); check("shr", d32, 32'h0800_0000);
        op32(3'd0, 4'd0, 4'd2, 4'd4, e, bn, dn);
        rd32(4'd0, d32); check("r0_wb_ignored", d32, 0);

        // Same register for all three operands; SUB and AND/OR
        ld32(4'd3, 32'd10);
        op32(3'd0, 4'd3, 4'd3, 4'd3, e, bn, dn);
        rd32(4'd3, d32); check("add_same_reg", d32, 32'd20);
        op32(3'd1, 4'd10, 4'd3, 4'd2, e, bn, dn);
        rd32(4'd10, d32); check("sub_wrap", d32, 32'h8000_0014);
        ld32(4'd12, 32'hF0F0_1234); ld32(4'd13, 32'h0FF0_FF00);
        op32(3'd2, 4'd14, 4'd12, 4'd13, e, bn, dn);
        rd32(4'd14, d32); check("and", d32, 32'h00F0_1200);
        op32(3'd3, 4'd14, 4'd12, 4'd13, e, bn, dn);
        rd32(4'd14, d32); check("or", d32, 32'hFFF0_FF34);

        // Load and start in the same cycle: TY sees the new R2 (R4=4)
        b32.ld_en = 1'b1; b32.ld_addr = 4'd2; b32.ld_data = 32'd100;
        op32(3'd0, 4'd11, 4'd2, 4'd4, e, bn, dn);
        rd32(4'd11, d32); check("ld_with_start", d32, 32'd104);

        // Start and load while busy are ignored
        ld32(4'd2, 32'd5); ld32(4'd4, 32'd7);
        b32.start = 1'b1; b32.op = 3'd0; b32.ra = 4'd6; b32.rb = 4'd2; b32.rc = 4'd4;
        @(negedge clk);
        b32.start = 1'b0;
        b32.ld_en = 1'b1; b32.ld_addr = 4'd9; b32.ld_data = 32'd55;
        @(negedge clk);
        b32.ld_en = 1'b0;
        b32.start = 1'b1; b32.ra = 4'd7;
        @(negedge clk);
        b32.start = 1'b0;
        pulses = 0;
        repeat (8) begin
            if (b32.done) pulses++;
            @(negedge clk);
        end
        check("busy_start_one_done", pulses, 1);
        rd32(4'd6, d32); check("busy_first_result", d32, 32'd12);
        rd32(4'd7, d32); check("busy_start_dropped", d32, 0);
        rd32(4'd9, d32); check("busy_ld_dropped", d32, 0);

        // clr in TEX aborts the sequence
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        ld32(4'd2, 32'd5); ld32(4'd4, 32'd7);
        b32.start = 1'b1; b32.op = 3'd0; b32.ra = 4'd5; b32.rb = 4'd2; b32.rc = 4'd4;
        @(negedge clk);
        b32.start = 1'b0;
        @(negedge clk);
        check("tex_busy_before_clr", b32.busy, 1);
        clr = 1'b1;
        #1;
        check("clr_busy_async", b32.busy, 0);
        check("clr_done_async", b32.done, 0);
        @(negedge clk);
        clr = 1'b0;
        repeat (4) @(negedge clk);
        rd32(4'd5, d32); check("clr_no_wb", d32, 0);
        check("clr_hi", b32.hi, 0);

        // 16-bit instance
        ld16(3'd2, 16'd5); ld16(3'd4, 16'd7);
        op16(3'd0, 3'd5, 3'd2, 3'd4, e, bn, dn);
        rd16(3'd5, d16); check("w16_add_r5", d16, 16'd12);
        check("w16_add_edges", e, 3);
        check("w16_add_busy_cycles", bn, 3);
        check("w16_add_done_one_cycle", dn, 0);
        ld16(3'd2, 16'hFFF9); ld16(3'd4, 16'd2);
        op16(3'd7, 3'd5, 3'd2, 3'd4, e, bn, dn);
        check("w16_div_lo", b16.lo, 16'hFFFD);
        check("w16_div_hi", b16.hi, 16'hFFFF);
        check("w16_div_edges", e, 4);
        ld16(3'd4, 16'd0);
        op16(3'd7, 3'd5, 3'd2, 3'd4, e, bn, dn);
        check("w16_div0_lo", b16.lo, 16'hFFFF);
        check("w16_div0_hi", b16.hi, 16'hFFF9);
        check("w16_div0_flag", b16.div0, 1);
        ld16(3'd2, 16'hFFFA); ld16(3'd4, 16'd4);
        op16(3'd6, 3'd5, 3'd2, 3'd4, e, bn, dn);
        check("w16_mul_lo", b16.lo, 16'hFFE8);
        check("w16_mul_hi", b16.hi, 16'hFFFF);
        check("w16_mul_div0_cleared", b16.div0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bus_datapath_seq.md
BUS_DATAPATH_SEQ -- requirements
Module: bus_datapath_seq

Interface
REQ-001 Parameter DATA_W, default 32: width of the bus, every register, and the ALU operands.
REQ-002 Parameter NUM_REGS, default 16: number of general registers; a power of 2, at least 2; AW = log2(NUM_REGS).
REQ-003 Parameter ZERO_R0, default 1: when 1, R0 reads as zero and ignores writes.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 clr  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  request one operation; sampled only in IDLE.
REQ-007 op  in  3  operation code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR, 6 MUL, 7 DIV.
REQ-008 ra, rb, rc  in  AW each  destination, first source and second source register addresses; sampled with start.
REQ-009 ld_en, ld_addr[AW], ld_data[DATA_W]  in  external register write port (memory-data path).
REQ-010 rd_addr  in  AW; rd_data  out  DATA_W  combinational read of the addressed register.
REQ-011 bus_out  out  DATA_W  current bus value, for observation.
REQ-012 busy, done, div0  out  1 each; hi, lo  out  DATA_W each  HI and LO register contents.

Function
REQ-013 States: IDLE, TY, TEX, TWB, THI; only IDLE accepts start.
REQ-014 IDLE: on start=1, latch op, ra, rb and rc, then go to TY; busy=1 in every state other than IDLE.
REQ-015 TY: bus = R[rb]; Y <= bus; go to TEX.
REQ-016 TEX: bus = R[rc]; the ALU computes from Y and the bus; result is latched into {Z_HI, Z_LO}; go to TWB.
REQ-017 TWB, ops 0-5: bus = Z_LO; R[ra] <= bus; go to IDLE.
REQ-018 TWB, ops 6-7: bus = Z_LO; LO <= bus; go to THI.
REQ-019 THI: bus = Z_HI; HI <= bus; go to IDLE.
REQ-020 In IDLE, bus = R[rd_addr].
REQ-021 done is registered and is 1 for exactly one cycle: the cycle immediately after the final write edge.
REQ-022 Latency, counted in edges from the start-sampling edge to the final write: ops 0-5 take 3 edges; MUL and DIV take 4 edges.
REQ-023 ADD and SUB are modulo 2^DATA_W; Z_HI = 0.
REQ-024 AND and OR are bitwise.
REQ-025 SHL and SHR are logical shifts of Y by the low log2(DATA_W) bits of the operand; the upper operand bits are ignored.
REQ-026 MUL: {Z_HI, Z_LO} = signed Y times signed operand, full 2*DATA_W-bit result.
REQ-027 DIV: Z_LO = signed quotient of Y divided by the operand, truncated toward zero; Z_HI = remainder, which takes the sign of the dividend.
REQ-028 DIV by zero: Z_LO = all ones, Z_HI = Y, div0 <= 1.
REQ-029 div0 is cleared by the next accepted start.
REQ-030 DIV of the most negative value by -1: Z_LO = the most negative value, Z_HI = 0, div0 = 0.
REQ-031 ld_en=1 in IDLE: R[ld_addr] <= ld_data at the next edge.
REQ-032 ld_en while busy is ignored.
REQ-033 start and ld_en together in IDLE: both are accepted; TY reads the newly loaded value if ld_addr = rb.
REQ-034 start while busy is ignored and is not queued.
REQ-035 ZERO_R0=1: R0 reads 0, and writes to R0 from TWB or ld_en are discarded without error.
REQ-036 ra = rb = rc is legal; operands are read before the writeback.

Reset
REQ-037 clr=1 forces, without waiting for a clock edge: state=IDLE, busy=0, done=0, div0=0.
REQ-038 clr=1 forces all registers R0..R(NUM_REGS-1), Y, Z_HI, Z_LO, HI and LO to 0.
REQ-039 clr during a sequence aborts it; no writeback occurs after clr is released.
REQ-040 The first start is accepted at the first rising edge at which clr=0.

Verification
REQ-041 Load R2=5 and R4=7, then start ADD ra=5, rb=2, rc=4 -> R5=12, done exactly 3 edges after start, busy high for 3 cycles.
REQ-042 R2=-6, R4=4, MUL -> LO=0xFFFFFFE8, HI=0xFFFFFFFF, R-file unchanged, done after 4 edges.
REQ-043 R2=-7, R4=2, DIV -> LO=-3, HI=-1; then with R4=0, DIV -> LO=0xFFFFFFFF, HI=-7, div0=1.
REQ-044 Second start asserted during TEX -> ignored, with exactly one done pulse; clr asserted in TEX -> R5 stays 0 and busy falls immediately.
REQ-045 Load R0=9 with ZERO_R0=1 -> rd_data=0; SHL of R2=1 by R4=33 -> shift of 1, result 2.
REQ-046 Instantiate DATA_W=16, NUM_REGS=8 and repeat REQ-041 and REQ-043 with 16-bit expected values.
